// File: rtl/bin2bcd_if.sv
// Handshake bundle between a producer of binary values (e.g. the divider)
// and the sequential binary-to-BCD converter.
interface bin2bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, WIDTH clocks from the
// start-sampling edge to a one-cycle done pulse; bcd only updates on completion.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [BW-1:0]    wb_q,    wb_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [BW-1:0]    bcd_q,   bcd_d;
    logic             done_q,  done_d;

    logic [BW-1:0]    wb_adj;
    logic [BW-1:0]    wb_shift;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        sr_d    = sr_q;
        wb_d    = wb_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;

        // Correct each digit before the shift so it carries properly into the next digit.
        wb_adj = wb_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (wb_q[4*i +: 4] >= 4'd5) wb_adj[4*i +: 4] = wb_q[4*i +: 4] + 4'd3;
        end
        wb_shift = BW'({wb_adj, sr_q[WIDTH-1]});

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = bus.bin;
                    wb_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                wb_d = wb_shift;
                sr_d = sr_q << 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = wb_shift;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
endmodule
